// File: rtl/up_down_pkg.sv
// Shared constants, direction encoding and the terminal-count helper for the up/down counter.
package up_down_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  function automatic int unsigned max_count(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/up_down_next.sv
// Combinational next-count logic: one step up or down, wrapping by default,
// or saturating at 0 / 2**WIDTH-1 when UP_DOWN_COUNTER_SAT_EN is defined.
module up_down_next
  import up_down_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic [WIDTH-1:0] cur,
  input  dir_e             dir,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(max_count(WIDTH));

  always_comb begin
    nxt = cur;
`ifdef UP_DOWN_COUNTER_SAT_EN
    if (dir == DIR_UP) nxt = (cur == MAX_V) ? MAX_V : cur + 1'b1;
    else               nxt = (cur == '0)    ? '0    : cur - 1'b1;
`else
    // Natural modulo-2**WIDTH wrap from the adder width; the terminal
    // constant is only needed in saturating builds.
    if (dir == DIR_UP) nxt = cur + 1'b1;
    else               nxt = cur - 1'b1;
`endif
  end

`ifndef UP_DOWN_COUNTER_SAT_EN
  logic unused_max;
  assign unused_max = ^MAX_V;
`endif

endmodule

// File: rtl/up_down_counter.sv
// Registered up/down counter: steps every clock, synchronous active-high reset.
// Build option UP_DOWN_COUNTER_SAT_EN selects saturating instead of wrapping arithmetic.
module up_down_counter
  import up_down_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d, step_nxt;

  up_down_next #(.WIDTH(WIDTH)) u_next (
    .cur (count_q),
    .dir (dir_e'(d)),
    .nxt (step_nxt)
  );

  // Reset wins over any direction.
  always_comb begin
    count_d = step_nxt;
    if (rst) count_d = '0;
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

  a_d_known: assert property (@(posedge clk) !rst |-> !$isunknown(d))
    else $error("up_down_counter: direction input is X/Z while counting");

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter; expectations follow the wrap or saturating build.
module tb_up_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d   = 1'b1;
  logic [3:0] count;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef UP_DOWN_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  up_down_counter #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .d     (d),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive between edges, advance one posedge, then sample on the falling edge.
  task automatic step(input logic r, input logic dir);
    rst = r;
    d   = dir;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // 1. reset
    step(1'b1, 1'b1);
    chk("reset_first", count, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      chk("reset_hold", count, 4'd0);
    end

    // 2. count up to 10
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1);
      chk("count_up", count, 4'(i));
    end

    // 4. down one, reset, then down from 0
    step(1'b0, 1'b0);
    chk("down_from_10", count, 4'd9);
    step(1'b1, 1'b0);
    chk("reset_from_9", count, 4'd0);
    step(1'b0, 1'b0);
    chk("down_from_0", count, SAT ? 4'd0 : 4'd15);
    step(1'b0, 1'b0);
    chk("down_from_0_b", count, SAT ? 4'd0 : 4'd14);

    // 3. sixteen up edges from 0
    step(1'b1, 1'b1);
    chk("reset_pre_wrap", count, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1);
      if (i < 16) chk("up_to_15", count, 4'(i));
      else        chk("up_from_15", count, SAT ? 4'd15 : 4'd0);
    end
    step(1'b0, 1'b1);
    chk("up_after_top", count, SAT ? 4'd15 : 4'd1);

    // 5. reset mid-count at 7, release counting down
    step(1'b1, 1'b1);
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b1);
    chk("reach_7", count, 4'd7);
    step(1'b1, 1'b0);
    chk("reset_mid", count, 4'd0);
    step(1'b0, 1'b0);
    chk("rel_down_1", count, SAT ? 4'd0 : 4'd15);
    step(1'b0, 1'b0);
    chk("rel_down_2", count, SAT ? 4'd0 : 4'd14);
    step(1'b0, 1'b1);
    chk("rel_up_after", count, SAT ? 4'd1 : 4'd15);

    // 6. direction flip every edge from 5
    step(1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1);
    chk("reach_5", count, 4'd5);
    step(1'b0, 1'b1); chk("flip_up_1",   count, 4'd6);
    step(1'b0, 1'b0); chk("flip_down_1", count, 4'd5);
    step(1'b0, 1'b1); chk("flip_up_2",   count, 4'd6);
    step(1'b0, 1'b0); chk("flip_down_2", count, 4'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
